// File: rtl/ipv4_checksum_arbiter_if.sv
// AXI-Stream style handshake bundle (tvalid/tready/tdata) used by the
// checksum arbiter for requester, response and generator-side ports.
interface ipv4_checksum_arbiter_if #(
  parameter int DATALEN = 16
);
  logic               tvalid;
  logic               tready;
  logic [DATALEN-1:0] tdata;

  modport master (
    output tvalid,
    output tdata,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    output tready
  );
endinterface

// File: rtl/ipv4_checksum_arbiter.sv
// Round-robin sharing of one IPv4 checksum generator among NUM_REQ requesters.
// Define IPV4_CKSUM_ARB_ORPHAN_CHECK_EN to build the sticky orphan-result flag.
module ipv4_checksum_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int GEN_LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  ipv4_checksum_arbiter_if.slave  ipv4_header_req   [NUM_REQ],
  ipv4_checksum_arbiter_if.master ipv4_checksum_rsp [NUM_REQ],
  ipv4_checksum_arbiter_if.master gen_header,
  ipv4_checksum_arbiter_if.slave  gen_checksum,
  output logic err_orphan_rsp
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(NUM_REQ + 1);
  localparam logic [IW:0] NREQ = (IW+1)'(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("ipv4_checksum_arbiter: NUM_REQ must be 2..16");
  end

  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] rsp_ready;
  logic [NUM_REQ-1:0] inflight;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] done_vec;
  logic [159:0]       req_data [NUM_REQ];
  logic [15:0]        rsp_data [NUM_REQ];

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] grant_idx;
  logic [IW:0]   sum;
  logic          grant;

  logic [IW-1:0] tag_q [NUM_REQ];
  logic [IW-1:0] wr_ptr;
  logic [IW-1:0] rd_ptr;
  logic [IW-1:0] pop_tag;
  logic [CW-1:0] tag_cnt;
  logic          pop;
  logic          orphan;
  logic          blank;

  logic          hdr_valid;
  logic [159:0]  hdr_data;
  logic          unused_gen_tready;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    return (v == IW'(NUM_REQ - 1)) ? '0 : v + 1'b1;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign req_valid[g] = ipv4_header_req[g].tvalid;
    assign req_data[g]  = ipv4_header_req[g].tdata;
    assign ipv4_header_req[g].tready = req_ready[g];
    assign ipv4_checksum_rsp[g].tvalid = rsp_valid[g];
    assign ipv4_checksum_rsp[g].tdata  = rsp_data[g];
    assign rsp_ready[g] = ipv4_checksum_rsp[g].tready;
  end

  // One outstanding header per requester, counting its undrained result.
  assign eligible = req_valid & ~inflight & ~rsp_valid & {NUM_REQ{!rst}};

  always_comb begin
    rot       = NUM_REQ'({eligible, eligible} >> rr_ptr);
    grant     = 1'b0;
    sum       = '0;
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        grant = 1'b1;
        sum   = {1'b0, rr_ptr} + (IW+1)'(k);
      end
    end
    if (sum >= NREQ) begin
      sum = sum - NREQ;
    end
    grant_idx = sum[IW-1:0];
  end

  assign req_ready = grant ? (NUM_REQ'(1) << grant_idx) : '0;

  assign pop_tag  = tag_q[rd_ptr];
  assign pop      = gen_checksum.tvalid && !blank && (tag_cnt != '0);
  assign orphan   = gen_checksum.tvalid && !blank && (tag_cnt == '0);
  assign done_vec = pop ? (NUM_REQ'(1) << pop_tag) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      inflight  <= '0;
      rsp_valid <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tag_cnt   <= '0;
      hdr_valid <= 1'b0;
    end else begin
      hdr_valid <= grant;
      if (grant) begin
        rr_ptr <= wrap_inc(grant_idx);
        wr_ptr <= wrap_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= wrap_inc(rd_ptr);
      end
      tag_cnt   <= tag_cnt + CW'(grant) - CW'(pop);
      inflight  <= (inflight | req_ready) & ~done_vec;
      rsp_valid <= (rsp_valid & ~rsp_ready) | done_vec;
    end
  end

  always_ff @(posedge clk) begin
    if (grant) begin
      tag_q[wr_ptr] <= grant_idx;
      hdr_data      <= req_data[grant_idx];
    end
    if (pop) begin
      rsp_data[pop_tag] <= gen_checksum.tdata;
    end
  end

  assign gen_header.tvalid  = hdr_valid;
  assign gen_header.tdata   = hdr_data;
  assign gen_checksum.tready = 1'b1;
  assign unused_gen_tready  = gen_header.tready;

`ifdef IPV4_CKSUM_ARB_ORPHAN_CHECK_EN
  localparam int BW = $clog2(GEN_LATENCY + 2);
  logic [BW-1:0] blank_cnt;
  logic          err_q;

  // Generator has no reset: ignore its beats until stray results flush out.
  assign blank = (blank_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      blank_cnt <= BW'(GEN_LATENCY + 1);
      err_q     <= 1'b0;
    end else begin
      if (blank) begin
        blank_cnt <= blank_cnt - 1'b1;
      end
      if (orphan) begin
        err_q <= 1'b1;
        $error("ipv4_checksum_arbiter: generator result with no outstanding tag");
      end
    end
  end

  assign err_orphan_rsp = err_q;
`else
  logic unused_orphan;

  assign blank          = 1'b0;
  assign unused_orphan  = orphan;
  assign err_orphan_rsp = 1'b0;
`endif
endmodule

// File: tb/tb_ipv4_checksum_arbiter.sv
// Bench for ipv4_checksum_arbiter: random requesters, behavioural generator,
// round-robin reference model and per-requester result scoreboard.
`timescale 1ns/1ps
module tb_ipv4_checksum_arbiter;
  localparam int N  = 4;
  localparam int GL = 2;
`ifdef IPV4_CKSUM_ARB_ORPHAN_CHECK_EN
  localparam logic ORPH = 1'b1;
`else
  localparam logic ORPH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [N-1:0] hv = '0;
  logic [N-1:0] rr = '1;
  logic [N-1:0] rdy;
  logic [N-1:0] rv;
  logic [159:0] hd [N];
  logic [15:0]  rdat [N];
  logic         err;

  ipv4_checksum_arbiter_if #(.DATALEN(160)) req_if [N] ();
  ipv4_checksum_arbiter_if #(.DATALEN(16))  rsp_if [N] ();
  ipv4_checksum_arbiter_if #(.DATALEN(160)) gh_if ();
  ipv4_checksum_arbiter_if #(.DATALEN(16))  gc_if ();

  for (genvar g = 0; g < N; g++) begin : g_con
    assign req_if[g].tvalid = hv[g];
    assign req_if[g].tdata  = hd[g];
    assign rdy[g]           = req_if[g].tready;
    assign rsp_if[g].tready = rr[g];
    assign rv[g]            = rsp_if[g].tvalid;
    assign rdat[g]          = rsp_if[g].tdata;
  end

  ipv4_checksum_arbiter #(
    .NUM_REQ(N),
    .GEN_LATENCY(GL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ipv4_header_req(req_if),
    .ipv4_checksum_rsp(rsp_if),
    .gen_header(gh_if),
    .gen_checksum(gc_if),
    .err_orphan_rsp(err)
  );

  function automatic logic [15:0] cksum(input logic [159:0] h);
    int unsigned s = 0;
    for (int k = 0; k < 10; k++) begin
      if (k != 5) s += 32'(h[159-16*k -: 16]);
    end
    while (s > 32'hffff) s = (s & 32'hffff) + (s >> 16);
    return ~s[15:0];
  endfunction

  function automatic logic [159:0] rand_hdr();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Behavioural generator: fixed latency, no reset, ignores backpressure.
  logic        gv_pipe [GL];
  logic [15:0] gd_pipe [GL];
  logic        inj_v = 1'b0;
  logic [15:0] inj_d = '0;

  assign gh_if.tready = 1'b1;
  assign gc_if.tvalid = gv_pipe[GL-1] | inj_v;
  assign gc_if.tdata  = inj_v ? inj_d : gd_pipe[GL-1];

  always @(posedge clk) begin
    gv_pipe[0] <= gh_if.tvalid;
    gd_pipe[0] <= cksum(gh_if.tdata);
    for (int k = 1; k < GL; k++) begin
      gv_pipe[k] <= gv_pipe[k-1];
      gd_pipe[k] <= gd_pipe[k-1];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model and scoreboard.
  logic [N-1:0] outst = '0;
  logic [N-1:0] acc_now = '0;
  logic [N-1:0] prev_rv = '0;
  logic [N-1:0] prev_rr = '0;
  logic [N-1:0] exp_g;
  logic [15:0]  prev_d [N];
  logic [15:0]  exp_q [N][$];
  int           acc_cyc [N];
  int           glog [$];
  int           mptr = 0;
  int           idx;

  always @(negedge clk) begin
    acc_now = '0;
    if (rst) begin
      outst   = '0;
      mptr    = 0;
      prev_rv = '0;
      foreach (exp_q[i]) exp_q[i].delete();
      chk("rst_tready", 32'(rdy), 0);
    end else begin
      exp_g = '0;
      for (int k = 0; k < N; k++) begin
        idx = (mptr + k) % N;
        if (exp_g == '0 && hv[idx] && !outst[idx]) exp_g[idx] = 1'b1;
      end
      chk("grant", 32'(rdy), 32'(exp_g));
      for (int i = 0; i < N; i++) begin
        if (rv[i]) begin
          if (!prev_rv[i]) begin
            chk("rsp_owner", 32'(outst[i]), 1);
            chk("latency", cyc - acc_cyc[i], GL + 2);
          end else if (!prev_rr[i]) begin
            chk("rsp_hold", 32'(rdat[i]), 32'(prev_d[i]));
          end
          if (rr[i]) begin
            if (exp_q[i].size() != 0)
              chk("rsp_data", 32'(rdat[i]), 32'(exp_q[i].pop_front()));
            outst[i] = 1'b0;
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (hv[i] && rdy[i]) begin
          acc_now[i] = 1'b1;
          outst[i]   = 1'b1;
          exp_q[i].push_back(cksum(hd[i]));
          acc_cyc[i] = cyc;
          mptr       = (i + 1) % N;
          glog.push_back(i);
        end
      end
      prev_rv = rv;
      prev_rr = rr;
      prev_d  = rdat;
    end
  end

  // Driver: auto mode randomizes, manual mode drops valid after acceptance.
  int vprob [N];
  int rprob [N];
  bit auto_en = 1'b0;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (auto_en) begin
        if (acc_now[i] || !hv[i]) begin
          hv[i] = (int'($urandom_range(99)) < vprob[i]);
          hd[i] = rand_hdr();
        end
        rr[i] = (int'($urandom_range(99)) < rprob[i]);
      end else if (acc_now[i]) begin
        hv[i] = 1'b0;
      end
    end
  end

  task automatic wait_quiet(input int lim);
    int n = 0;
    while ((hv != '0 || outst != '0) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("quiet", 32'(hv | outst), 0);
  endtask

  task automatic wait_rv(input int i, input int lim);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rv[i] && n < lim);
    chk("wait_rsp", 32'(rv[i]), 1);
  endtask

  task automatic stop_auto();
    foreach (vprob[i]) vprob[i] = 0;
    foreach (rprob[i]) rprob[i] = 100;
    wait_quiet(100);
    auto_en = 1'b0;
  endtask

  task automatic pulse_rst();
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  int n2;
  int last;
  int cnt;

  initial begin
    foreach (hd[i]) hd[i] = rand_hdr();
    foreach (vprob[i]) vprob[i] = 0;
    foreach (rprob[i]) rprob[i] = 100;
    hv = '1;
    repeat (3) @(posedge clk);
    #2 hv = '0;
    @(negedge clk);
    chk("rst_gen_tvalid", 32'(gh_if.tvalid), 0);
    chk("rst_rsp_tvalid", 32'(rv), 0);
    chk("rst_err", 32'(err), 0);
    chk("gen_tready", 32'(gc_if.tready), 1);

    // Known header example.
    @(posedge clk); #2;
    rst   = 1'b0;
    hd[0] = 160'h4500_0073_0000_4000_4011_0000_c0a8_0001_c0a8_00c7;
    hv[0] = 1'b1;
    wait_rv(0, 20);
    chk("example_cksum", 32'(rdat[0]), 32'h0000_b861);
    chk("example_others", 32'(rv[N-1:1]), 0);
    wait_quiet(30);

    // All requesters busy: strict rotation starting after requester 0.
    glog.delete();
    foreach (vprob[i]) vprob[i] = 100;
    auto_en = 1'b1;
    repeat (40) @(posedge clk);
    stop_auto();
    chk("rot_count", 32'(glog.size() >= 12), 1);
    chk("rot_first", glog[0], 1);
    for (int k = 1; k < 12 && k < glog.size(); k++)
      chk("rot_order", glog[k], (glog[k-1] + 1) % N);

    // Requester 2 stalls its response; others rotate among themselves.
    glog.delete();
    foreach (vprob[i]) vprob[i] = 100;
    rprob[2] = 0;
    auto_en  = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    n2   = 0;
    last = -1;
    foreach (glog[k]) begin
      if (glog[k] == 2) n2++;
      else begin
        if (last >= 0) chk("stall_order", glog[k], (last == 3) ? 0 : (last == 0 ? 1 : 3));
        last = glog[k];
      end
    end
    chk("stall_no_regrant", 32'(n2 <= 1), 1);
    chk("stall_held", 32'(rv[2]), 32'(n2 == 1));
    stop_auto();

    // rr_ptr at 2 with requesters 1 and 3, then return/grant overlap.
    @(posedge clk); #2;
    hd[1] = rand_hdr();
    hv[1] = 1'b1;
    wait_quiet(30);
    glog.delete();
    @(posedge clk); #2;
    hd[1] = rand_hdr();
    hd[3] = rand_hdr();
    hv[1] = 1'b1;
    hv[3] = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!acc_now[1] && cnt < 10);
    repeat (3) @(posedge clk);
    #2 hd[0] = rand_hdr();
    hv[0] = 1'b1;
    wait_quiet(30);
    chk("ptr2_count", glog.size(), 3);
    if (glog.size() == 3) begin
      chk("ptr2_first", glog[0], 3);
      chk("ptr2_second", glog[1], 1);
      chk("ptr2_third", glog[2], 0);
    end

    // Reset mid-operation.
    glog.delete();
    foreach (vprob[i]) vprob[i] = 100;
    auto_en = 1'b1;
    cnt = 0;
    while (glog.size() < 3 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("mid_three_grants", 32'(glog.size() >= 3), 1);
    @(posedge clk); #2;
    auto_en = 1'b0;
    foreach (vprob[i]) vprob[i] = 0;
    hv  = '0;
    rr  = '1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_no_rsp", 32'(rv), 0);
    chk("mid_err", 32'(err), 0);
    @(posedge clk); #2;
    hd[2] = rand_hdr();
    hv[2] = 1'b1;
    wait_rv(2, 20);
    wait_quiet(30);

    // Orphan beat well after reset.
    pulse_rst();
    repeat (10) @(posedge clk);
    #2 inj_v = 1'b1;
    inj_d = 16'($urandom);
    @(posedge clk);
    #2 inj_v = 1'b0;
    @(negedge clk);
    chk("orphan_flag", 32'(err), 32'(ORPH));
    repeat (5) @(negedge clk);
    chk("orphan_sticky", 32'(err), 32'(ORPH));
    chk("orphan_no_rsp", 32'(rv), 0);

    // Random traffic and backpressure.
    foreach (vprob[i]) vprob[i] = 30 + int'($urandom_range(60));
    foreach (rprob[i]) rprob[i] = 20 + int'($urandom_range(80));
    auto_en = 1'b1;
    repeat (400) @(posedge clk);
    stop_auto();
    cnt = 0;
    foreach (exp_q[i]) cnt += exp_q[i].size();
    chk("drained", cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
